// File: rtl/hrange_arbiter.sv
// Round-robin front end that shares a single hrange generator core among NREQ requesters.
// Jobs run one at a time; yielded values and the done pulse are routed back to the granted requester.
module hrange_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic              _clock,
  input  logic              _reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_base,
  input  logic [NREQ*W-1:0] req_limit,
  input  logic [NREQ*W-1:0] req_step,
  output logic [W-1:0]      out_data,
  output logic [NREQ-1:0]   out_valid,
  input  logic [NREQ-1:0]   out_ready,
  output logic [NREQ-1:0]   out_done,
  output logic              busy,
  output logic [31:0]       yield_cnt,
  output logic [W-1:0]      gen_base,
  output logic [W-1:0]      gen_limit,
  output logic [W-1:0]      gen_step,
  output logic              gen_start,
  output logic              gen_reset,
  output logic              gen_ready,
  input  logic              gen_valid,
  input  logic              gen_done,
  input  logic [W-1:0]      gen_0
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [W-1:0]    base_q, base_d;
  logic [W-1:0]    limit_q, limit_d;
  logic [W-1:0]    step_q, step_d;
  logic [31:0]     yield_q, yield_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            done_seen_q, done_seen_d;

  logic [IW-1:0]   winner;
  logic [IW-1:0]   cand_idx;
  logic [IW-1:0]   next_ptr;
  logic            found;
  int              cand;

  // Rotating priority search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IW'(cand);
      if (!found && req_valid[cand_idx]) begin
        winner = cand_idx;
        found  = 1'b1;
      end
    end
  end

  assign next_ptr = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    base_d      = base_q;
    limit_d     = limit_q;
    step_d      = step_q;
    yield_d     = yield_q;
    done_d      = '0;
    done_seen_d = done_seen_q;
    req_ready   = '0;
    out_valid   = '0;
    out_data    = '0;
    gen_start   = 1'b0;
    gen_ready   = 1'b0;
    busy        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found && _reset_n) begin
          req_ready[winner] = 1'b1;
          grant_d           = winner;
          base_d            = req_base[winner*W +: W];
          limit_d           = req_limit[winner*W +: W];
          step_d            = req_step[winner*W +: W];
          yield_d           = '0;
          done_seen_d       = 1'b0;
          state_d           = START;
        end
      end
      START: begin
        gen_start = 1'b1;
        busy      = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        busy               = 1'b1;
        gen_ready          = out_ready[grant_q];
        out_valid[grant_q] = gen_valid;
        out_data           = gen_0;
        if (gen_valid && out_ready[grant_q]) yield_d = yield_q + 32'd1;
        // A done that coincides with a stalled beat is remembered until that beat drains.
        if ((gen_done || done_seen_q) && !(gen_valid && !out_ready[grant_q])) begin
          done_d[grant_q] = 1'b1;
          rr_ptr_d        = next_ptr;
          done_seen_d     = 1'b0;
          state_d         = IDLE;
        end else if (gen_done) begin
          done_seen_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      base_q      <= '0;
      limit_q     <= '0;
      step_q      <= '0;
      yield_q     <= '0;
      done_q      <= '0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      base_q      <= base_d;
      limit_q     <= limit_d;
      step_q      <= step_d;
      yield_q     <= yield_d;
      done_q      <= done_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign out_done  = done_q;
  assign yield_cnt = yield_q;
  assign gen_base  = base_q;
  assign gen_limit = limit_q;
  assign gen_step  = step_q;
  assign gen_reset = !_reset_n;

endmodule

// File: tb/tb_hrange_arbiter.sv
// Directed bench for hrange_arbiter with a small behavioural hrange core attached to the gen_* side.
// Single jobs are table driven; contention, fairness and mid-job reset are hand sequences.
module tb_hrange_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clock = 1'b0;
  logic              resetN;
  logic [NREQ-1:0]   reqValid;
  logic [NREQ-1:0]   reqReady;
  logic [NREQ*W-1:0] reqBase;
  logic [NREQ*W-1:0] reqLimit;
  logic [NREQ*W-1:0] reqStep;
  logic [W-1:0]      outData;
  logic [NREQ-1:0]   outValid;
  logic [NREQ-1:0]   outReady;
  logic [NREQ-1:0]   outDone;
  logic              busy;
  logic [31:0]       yieldCnt;
  logic [W-1:0]      genBase;
  logic [W-1:0]      genLimit;
  logic [W-1:0]      genStep;
  logic              genStart;
  logic              genReset;
  logic              genReady;
  logic              genValid;
  logic              genDone;
  logic [W-1:0]      gen0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int               idx;
    int               base;
    int               limit;
    int               step;
    int               mode;
    int               expCount;
    logic [5:0][31:0] expVals;
  } vec_t;

  vec_t vecs [6];

  hrange_arbiter #(.NREQ(NREQ), .W(W)) dut (
    ._clock    (clock),
    ._reset_n  (resetN),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_base  (reqBase),
    .req_limit (reqLimit),
    .req_step  (reqStep),
    .out_data  (outData),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_done  (outDone),
    .busy      (busy),
    .yield_cnt (yieldCnt),
    .gen_base  (genBase),
    .gen_limit (genLimit),
    .gen_step  (genStep),
    .gen_start (genStart),
    .gen_reset (genReset),
    .gen_ready (genReady),
    .gen_valid (genValid),
    .gen_done  (genDone),
    .gen_0     (gen0)
  );

  always #5 clock = ~clock;

  // Behavioural core: loads on start, holds a value until accepted, pulses done once cur >= limit.
  logic signed [W-1:0] coreCur = '0;
  logic signed [W-1:0] coreLim = '0;
  logic signed [W-1:0] coreStep = '0;
  logic                coreActive = 1'b0;

  always @(posedge clock) begin
    if (genReset) begin
      coreActive <= 1'b0;
    end else if (genStart) begin
      coreCur    <= genBase;
      coreLim    <= genLimit;
      coreStep   <= genStep;
      coreActive <= 1'b1;
    end else if (coreActive) begin
      if (genDone) coreActive <= 1'b0;
      else if (genValid && genReady) coreCur <= coreCur + coreStep;
    end
  end

  assign genValid = coreActive && (coreCur < coreLim);
  assign genDone  = coreActive && !(coreCur < coreLim);
  assign gen0     = coreCur;

  function automatic logic [31:0] oh(input int i);
    return 32'd1 << i;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setJob(input int idx, input int base, input int limit, input int step);
    reqBase[idx*W +: W]  = base;
    reqLimit[idx*W +: W] = limit;
    reqStep[idx*W +: W]  = step;
  endtask

  // Waits (bounded) for req_ready, checks it is one-hot on idx, and returns just after the accepting edge.
  task automatic waitGrant(input int idx);
    bit seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clock);
      if (reqReady != '0) begin
        checkOutput($sformatf("req_ready grant req%0d", idx), 32'(reqReady), oh(idx));
        seen = 1'b1;
      end else begin
        @(posedge clock);
        #1;
      end
    end
    if (seen) begin
      @(posedge clock);
      #1;
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL grant timeout req%0d: got req_ready 0, expected bit %0d", idx, idx);
    end
  endtask

  task automatic applyStimulus(input int idx, input int base, input int limit, input int step, input bit keep);
    setJob(idx, base, limit, step);
    reqValid[idx] = 1'b1;
    waitGrant(idx);
    if (!keep) reqValid[idx] = 1'b0;
  endtask

  // Runs one granted job from its START cycle through out_done; mode 1 stalls with out_ready pattern 1,0,0.
  task automatic collectJob(input string tag, input int idx, input int base, input int limit, input int step,
                            input int mode, input int expCount, input logic [5:0][31:0] expVals,
                            input logic [31:0] expReadyAtDone);
    int              n = 0;
    bit              done = 1'b0;
    logic [NREQ-1:0] want;
    want = NREQ'(oh(idx));
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      outReady = (mode == 0 || (cyc % 3) == 1) ? '1 : ~want;
      @(negedge clock);
      if (cyc == 0) begin
        checkOutput({tag, " gen_start"}, 32'(genStart), 32'd1);
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        checkOutput({tag, " gen_base"}, genBase, base);
        checkOutput({tag, " gen_limit"}, genLimit, limit);
        checkOutput({tag, " gen_step"}, genStep, step);
      end
      if (cyc == 1) checkOutput({tag, " gen_start low"}, 32'(genStart), 32'd0);
      if (cyc >= 1 && outDone == '0)
        checkOutput({tag, " gen_ready"}, 32'(genReady), 32'(outReady[idx]));
      if (outValid != '0) begin
        checkOutput({tag, " out_valid"}, 32'(outValid), oh(idx));
        if (outValid[idx] && outReady[idx]) begin
          if (n < expCount) checkOutput($sformatf("%s value%0d", tag, n), outData, expVals[n]);
          else checkOutput({tag, " extra beat count"}, n + 1, expCount);
          n++;
        end
      end
      if (outDone != '0) begin
        checkOutput({tag, " out_done"}, 32'(outDone), oh(idx));
        checkOutput({tag, " yield_cnt"}, yieldCnt, expCount);
        checkOutput({tag, " beats"}, n, expCount);
        checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
        checkOutput({tag, " req_ready at done"}, 32'(reqReady), expReadyAtDone);
        if (expCount == 0) checkOutput({tag, " empty done latency"}, cyc, 32'd2);
        done = 1'b1;
      end else begin
        checkOutput({tag, " req_ready while busy"}, 32'(reqReady), 32'd0);
      end
      @(posedge clock);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s done timeout: got no out_done, expected bit %0d", tag, idx);
    end
  endtask

  logic [5:0][31:0] v012;
  logic [5:0][31:0] v0123;
  logic [5:0][31:0] v78;

  initial begin
    vecs[0] = '{0, 0, 10, 2, 0, 5, {32'd0, 32'd8, 32'd6, 32'd4, 32'd2, 32'd0}};
    vecs[1] = '{2, 5, 8, 1, 1, 3, {32'd0, 32'd0, 32'd0, 32'd7, 32'd6, 32'd5}};
    vecs[2] = '{3, 4, 4, 1, 0, 0, {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
    vecs[3] = '{1, -3, 3, 2, 0, 3, {32'd0, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[4] = '{2, 10, 13, 1, 1, 3, {32'd0, 32'd0, 32'd0, 32'd12, 32'd11, 32'd10}};
    vecs[5] = '{0, -5, -4, 1, 0, 1, {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFB}};
    v012  = {32'd0, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0};
    v0123 = {32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
    v78   = {32'd0, 32'd0, 32'd0, 32'd0, 32'd8, 32'd7};

    resetN   = 1'b0;
    reqValid = 4'b0001;
    outReady = '0;
    reqBase  = '0;
    reqLimit = '0;
    reqStep  = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset req_ready", 32'(reqReady), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset yield_cnt", yieldCnt, 32'd0);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset out_done", 32'(outDone), 32'd0);
    checkOutput("reset gen_start", 32'(genStart), 32'd0);
    checkOutput("reset gen_ready", 32'(genReady), 32'd0);
    checkOutput("reset gen_base", genBase, 32'd0);
    checkOutput("reset gen_reset", 32'(genReset), 32'd1);
    @(posedge clock);
    #1;
    reqValid = '0;
    resetN   = 1'b1;
    @(negedge clock);
    checkOutput("gen_reset released", 32'(genReset), 32'd0);
    @(posedge clock);
    #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].idx, vecs[i].base, vecs[i].limit, vecs[i].step, 1'b0);
      collectJob($sformatf("vec%0d", i), vecs[i].idx, vecs[i].base, vecs[i].limit, vecs[i].step,
                 vecs[i].mode, vecs[i].expCount, vecs[i].expVals, 32'd0);
    end

    // Mid-job reset: the job is abandoned without a done pulse.
    outReady = '1;
    applyStimulus(0, 0, 100, 1, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    resetN = 1'b0;
    @(negedge clock);
    checkOutput("midreset gen_reset", 32'(genReset), 32'd1);
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("midreset out_valid", 32'(outValid), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset yield_cnt", yieldCnt, 32'd0);
    checkOutput("midreset gen_ready", 32'(genReady), 32'd0);
    checkOutput("midreset gen_start", 32'(genStart), 32'd0);
    checkOutput("midreset gen_limit", genLimit, 32'd0);
    checkOutput("midreset out_done", 32'(outDone), 32'd0);
    checkOutput("midreset gen_reset held", 32'(genReset), 32'd1);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("post-reset out_done", 32'(outDone), 32'd0);
      checkOutput("post-reset busy", 32'(busy), 32'd0);
      @(posedge clock);
      #1;
    end

    // Contention: all four valid from rr_ptr=0, then a second round between req0 and req3.
    for (int i = 0; i < NREQ; i++) setJob(i, 0, 3, 1);
    reqValid = '1;
    waitGrant(0);
    reqValid[0] = 1'b0;
    collectJob("cont0", 0, 0, 3, 1, 0, 3, v012, oh(1));
    reqValid[1] = 1'b0;
    collectJob("cont1", 1, 0, 3, 1, 0, 3, v012, oh(2));
    reqValid[2] = 1'b0;
    collectJob("cont2", 2, 0, 3, 1, 0, 3, v012, oh(3));
    reqValid[3] = 1'b0;
    collectJob("cont3", 3, 0, 3, 1, 0, 3, v012, 32'd0);
    reqValid = 4'b1001;
    waitGrant(0);
    reqValid[0] = 1'b0;
    collectJob("round2 req0", 0, 0, 3, 1, 0, 3, v012, oh(3));
    reqValid[3] = 1'b0;
    collectJob("round2 req3", 3, 0, 3, 1, 0, 3, v012, 32'd0);

    // Fairness: req1 stays valid, req2 arrives while req1's job runs and must be served next.
    setJob(1, 0, 4, 1);
    setJob(2, 7, 9, 1);
    applyStimulus(1, 0, 4, 1, 1'b1);
    reqValid[2] = 1'b1;
    collectJob("fair req1", 1, 0, 4, 1, 0, 4, v0123, oh(2));
    reqValid[2] = 1'b0;
    collectJob("fair req2", 2, 7, 9, 1, 0, 2, v78, oh(1));
    reqValid[1] = 1'b0;
    collectJob("fair req1 again", 1, 0, 4, 1, 0, 4, v0123, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
